// File: rtl/alu_rmw_sequencer.sv
// -----------------------------------------------------------------------------
// alu_rmw_sequencer
//
// Purpose:
//   Multi-cycle read-modify-write controller for the 8-bit ALU. It handles the
//   (HL) forms of the CB-prefix rotates/shifts/SWAP and of ADD/ADC/SUB/SBC/AND/
//   XOR/OR/CP. It reads the operand byte over the memory port and drives the
//   ALU for exactly one cycle. It then captures the result and flags, writes
//   the byte back (except for CP) and pulses done. While busy it is the only
//   driver of the ALU inputs.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start/op/addr/yIn/fIn request from decode; sampled only in IDLE
//   busy/done/err         status; done and err are one-cycle pulses
//   result/fOut           captured ALU byte (held) / flags to commit on done
//   mem*                  CPU memory port; strobes are held until memAck
//   alu*                  ALU operands out, aluO/aluFOut back
//
// Optional feature (macro ALU_RMW_TIMEOUT_EN):
//   When the macro is defined, each memory access is bounded by TIMEOUT_CYCLES
//   cycles without memAck. After that the access is aborted with err=1. When
//   the macro is undefined, READ and WRITE wait for memAck indefinitely.
// -----------------------------------------------------------------------------
module alu_rmw_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [15:0] addr,
    input  logic [7:0]  yIn,
    input  logic [3:0]  fIn,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  result,
    output logic [3:0]  fOut,
    output logic [15:0] memAddr,
    output logic        memRead,
    output logic        memWrite,
    output logic [7:0]  memDataOut,
    input  logic [7:0]  memDataIn,
    input  logic        memAck,
    output logic [5:0]  aluOp,
    output logic [15:0] aluX,
    output logic [15:0] aluY,
    output logic [3:0]  aluFIn,
    input  logic [15:0] aluO,
    input  logic [3:0]  aluFOut
);

    localparam logic [5:0] OP_CP   = 6'h07;
    localparam logic [5:0] OP_LAST = 6'h13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  y_q, y_d;
    logic [3:0]  fin_q, fin_d;
    logic [7:0]  opnd_q, opnd_d;
    logic [7:0]  res_q, res_d;
    logic [3:0]  flags_q, flags_d;
    logic        abort_q, abort_d;

    // Only the low byte of the ALU result is used for an 8-bit write-back.
    logic unused_alu_hi;
    assign unused_alu_hi = ^aluO[15:8];

`ifdef ALU_RMW_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] wait_q, wait_d;
    logic          timeout;
    // The strobe has been high for TIMEOUT_CYCLES cycles with no ack once the
    // counter shows TIMEOUT_CYCLES-1 and this cycle also misses the ack.
    assign timeout = !memAck && (wait_q == CW'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    assign result = res_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        y_d        = y_q;
        fin_d      = fin_q;
        opnd_d     = opnd_q;
        res_d      = res_q;
        flags_d    = flags_q;
        abort_d    = abort_q;
`ifdef ALU_RMW_TIMEOUT_EN
        wait_d     = memAck ? wait_q : wait_q + CW'(1);
`endif
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        fOut       = 4'h0;
        memAddr    = 16'h0000;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        memDataOut = 8'h00;
        aluOp      = 6'h00;
        aluX       = 16'h0000;
        aluY       = 16'h0000;
        aluFIn     = 4'h0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    addr_d  = addr;
                    y_d     = yIn;
                    fin_d   = fIn;
                    // A 6-bit code above 0x13 covers op[5]=1 as well.
                    abort_d = (op > OP_LAST);
                    state_d = (op > OP_LAST) ? S_DONE : S_READ;
`ifdef ALU_RMW_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end
            end
            S_READ: begin
                busy    = 1'b1;
                memRead = 1'b1;
                memAddr = addr_q;
                if (memAck) begin
                    opnd_d  = memDataIn;
                    state_d = S_EXEC;
                end
`ifdef ALU_RMW_TIMEOUT_EN
                else if (timeout) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_EXEC: begin
                busy    = 1'b1;
                aluOp   = op_q;
                aluX    = {8'h00, opnd_q};
                aluY    = {8'h00, y_q};
                aluFIn  = fin_q;
                res_d   = aluO[7:0];
                flags_d = aluFOut;
                state_d = (op_q == OP_CP) ? S_DONE : S_WRITE;
`ifdef ALU_RMW_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            S_WRITE: begin
                busy       = 1'b1;
                memWrite   = 1'b1;
                memAddr    = addr_q;
                memDataOut = res_q;
                if (memAck) begin
                    state_d = S_DONE;
                end
`ifdef ALU_RMW_TIMEOUT_EN
                else if (timeout) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                err     = abort_q;
                fOut    = abort_q ? fin_q : flags_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            y_q     <= '0;
            fin_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            flags_q <= '0;
            abort_q <= 1'b0;
`ifdef ALU_RMW_TIMEOUT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            y_q     <= y_d;
            fin_q   <= fin_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            abort_q <= abort_d;
`ifdef ALU_RMW_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_rmw_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_rmw_sequencer
//
// Self-checking bench for alu_rmw_sequencer in its default build (no timeout).
// A stand-in ALU answers the DUT's ALU port. For every request the driver
// works out the expected cycle-by-cycle view of the sequencer's outputs. It
// derives this from the request, the planned memAck delays and a reference
// ALU function. A single compare process checks the DUT against that view
// each cycle. Directed requests pin the expected values to literals taken
// from hand calculation.
// -----------------------------------------------------------------------------
module tb_alu_rmw_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, memAck;
    logic [5:0]  op;
    logic [15:0] addr;
    logic [7:0]  yIn, memDataIn;
    logic [3:0]  fIn;
    logic        busy, done, err, memRead, memWrite;
    logic [7:0]  result, memDataOut;
    logic [3:0]  fOut, aluFIn, aluFOut;
    logic [15:0] memAddr, aluX, aluY, aluO;
    logic [5:0]  aluOp;

    always #5 clk = ~clk;

    alu_rmw_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
        .yIn(yIn), .fIn(fIn), .busy(busy), .done(done), .err(err),
        .result(result), .fOut(fOut), .memAddr(memAddr), .memRead(memRead),
        .memWrite(memWrite), .memDataOut(memDataOut), .memDataIn(memDataIn),
        .memAck(memAck), .aluOp(aluOp), .aluX(aluX), .aluY(aluY),
        .aluFIn(aluFIn), .aluO(aluO), .aluFOut(aluFOut)
    );

    // Reference 8-bit ALU. It returns {Z,N,H,C, result}.
    function automatic logic [11:0] alu_ref(input logic [5:0] o, input logic [7:0] x,
                                            input logic [7:0] y, input logic [3:0] f);
        logic [8:0] s;
        logic [7:0] r, zv;
        logic       c, n, h, co, cin;
        c = f[0]; n = 1'b0; h = 1'b0; co = 1'b0; cin = 1'b0; s = '0; r = '0;
        case (o)
            6'h00, 6'h01: begin
                cin = (o == 6'h01) ? c : 1'b0;
                s   = {1'b0, x} + {1'b0, y} + 9'(cin);
                r   = s[7:0];
                h   = ({1'b0, x[3:0]} + {1'b0, y[3:0]} + 5'(cin)) > 5'd15;
                co  = s[8];
            end
            6'h02, 6'h03, 6'h07: begin
                cin = (o == 6'h03) ? c : 1'b0;
                s   = {1'b0, x} - {1'b0, y} - 9'(cin);
                r   = (o == 6'h07) ? x : s[7:0];
                n   = 1'b1;
                h   = {1'b0, x[3:0]} < ({1'b0, y[3:0]} + 5'(cin));
                co  = s[8];
            end
            6'h04: begin r = x & y; h = 1'b1; end
            6'h05: r = x ^ y;
            6'h06: r = x | y;
            6'h08: begin r = {x[6:0], x[7]}; co = x[7]; end
            6'h09: begin r = {x[0], x[7:1]}; co = x[0]; end
            6'h0A: begin r = {x[6:0], c};    co = x[7]; end
            6'h0B: begin r = {c, x[7:1]};    co = x[0]; end
            6'h0C: begin r = {x[6:0], 1'b0}; co = x[7]; end
            6'h0D: begin r = {x[7], x[7:1]}; co = x[0]; end
            6'h0E: begin r = {1'b0, x[7:1]}; co = x[0]; end
            6'h0F: begin r = ~x; n = 1'b1; h = 1'b1; co = c; end
            6'h10: begin r = x + 8'd1; co = c; end
            6'h11: begin r = x - 8'd1; n = 1'b1; co = c; end
            6'h12: begin r = x; co = c; end
            6'h13: r = {x[3:0], x[7:4]};
            default: r = 8'h00;
        endcase
        zv = (o == 6'h07) ? s[7:0] : r;
        return {(zv == 8'h00), n, h, co, r};
    endfunction

    // Stand-in ALU. The upper result byte is deliberately non-zero so that a
    // leak into the 8-bit write path shows up.
    logic [11:0] alu_bus;
    always_comb begin
        alu_bus = alu_ref(aluOp, aluX[7:0], aluY[7:0], aluFIn);
        aluO    = {alu_bus[7:0] ^ 8'hA5, alu_bus[7:0]};
        aluFOut = alu_bus[11:8];
    end

    typedef struct {
        logic        busy, done, err, rd, wr, chk_res;
        logic [15:0] addr, ax, ay;
        logic [7:0]  wdata, res;
        logic [3:0]  fout, af;
        logic [5:0]  aop;
    } exp_t;

    exp_t e;
    bit   chk_en = 1'b0;
    int   vectors = 0, miscompares = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t idle_exp();
        exp_t r;
        r = '{default: 0};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] ex);
        vectors++;
        if (act !== ex) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, ex);
        end
    endtask

    // Compare process: runs 1 time unit after the driver has updated e.
    always begin
        @(negedge clk);
        #1;
        if (chk_en) begin
            chk("busy",     16'(busy),     16'(e.busy));
            chk("done",     16'(done),     16'(e.done));
            chk("err",      16'(err),      16'(e.err));
            chk("memRead",  16'(memRead),  16'(e.rd));
            chk("memWrite", 16'(memWrite), 16'(e.wr));
            chk("aluOp",    16'(aluOp),    16'(e.aop));
            chk("aluX",     aluX,          e.ax);
            chk("aluY",     aluY,          e.ay);
            chk("aluFIn",   16'(aluFIn),   16'(e.af));
            if (e.rd || e.wr) chk("memAddr", memAddr, e.addr);
            if (e.wr)         chk("memDataOut", 16'(memDataOut), 16'(e.wdata));
            if (e.done)       chk("fOut", 16'(fOut), 16'(e.fout));
            if (e.chk_res)    chk("result", 16'(result), 16'(e.res));
        end
    end

    // Drive junk onto all request and memory inputs. The caller then
    // overrides whatever has to hold specific values this cycle.
    task automatic junk();
        start     = 1'($urandom_range(0, 1));
        op        = 6'($urandom);
        addr      = 16'($urandom);
        yIn       = 8'($urandom);
        fIn       = 4'($urandom);
        memAck    = 1'($urandom_range(0, 1));
        memDataIn = 8'($urandom);
    endtask

    // One request, starting in an IDLE cycle. rw and ww are the wait cycles
    // before memAck on read and on write. rst_k >= 0 pulses reset in that
    // relative cycle and ends the request early. gap is the number of idle
    // cycles after done.
    task automatic txn(input logic [5:0] o, input logic [15:0] a, input logic [7:0] y,
                       input logic [3:0] f, input logic [7:0] data, input int rw, input int ww,
                       input logic [7:0] xres, input logic [3:0] xfl, input int rst_k,
                       input int gap);
        bit ill, cp;
        int kdone;
        ill   = (o > 6'h13);
        cp    = (o == 6'h07);
        kdone = ill ? 1 : (cp ? 3 + rw : 4 + rw + ww);
        for (int k = 0; k <= kdone; k++) begin
            @(negedge clk);
            reset = 1'b0;
            e = idle_exp();
            junk();
            if (k == 0) begin
                start = 1'b1; op = o; addr = a; yIn = y; fIn = f;
            end else if (k == kdone) begin
                e.busy = 1'b1; e.done = 1'b1; e.err = ill;
                e.fout = ill ? f : xfl;
                e.res = xres; e.chk_res = !ill;
            end else if (k <= 1 + rw) begin
                e.busy = 1'b1; e.rd = 1'b1; e.addr = a;
                memAck = (k == 1 + rw);
                if (memAck) memDataIn = data;
            end else if (k == 2 + rw) begin
                e.busy = 1'b1; e.aop = o; e.ax = {8'h00, data};
                e.ay = {8'h00, y}; e.af = f;
            end else begin
                e.busy = 1'b1; e.wr = 1'b1; e.addr = a; e.wdata = xres;
                memAck = (k == kdone - 1);
            end
            chk_en = 1'b1;
            if (k == rst_k) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                junk();
                start = 1'b0;
                e = idle_exp();
                e.chk_res = 1'b1; e.res = 8'h00;
                return;
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            reset = 1'b0;
            e = idle_exp();
            junk();
            start = 1'b0;
        end
    endtask

    initial begin
        logic [5:0]  o;
        logic [15:0] a;
        logic [7:0]  y, d, xr;
        logic [3:0]  f, xf;
        logic [11:0] rr;
        int          rw, ww, rk;

        reset = 1'b1; start = 1'b0; op = '0; addr = '0; yIn = '0; fIn = '0;
        memAck = 1'b0; memDataIn = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = idle_exp();
            e.chk_res = 1'b1; e.res = 8'h00;
            chk_en = 1'b1;
        end

        // SWAP 0xF1 -> 0x1F at 0xC000; the flags do not depend on fIn.
        txn(6'h13, 16'hC000, 8'h55, 4'b1111, 8'hF1, 0, 0, 8'h1F, 4'b0000, -1, 1);
        // ADD 0x3A + 0xC6 -> 0x00 with Z,H,C. Back-to-back with the next one.
        txn(6'h00, 16'h8123, 8'hC6, 4'b0000, 8'h3A, 0, 0, 8'h00, 4'b1011, -1, 0);
        // CP 0x42 vs 0x10: no write, result keeps the operand, N only.
        txn(6'h07, 16'h9000, 8'h10, 4'b0000, 8'h42, 0, 0, 8'h42, 4'b0100, -1, 1);
        // RL 0x80 with C=1 -> 0x01, C out. Acks are 3 and 2 cycles late.
        txn(6'h0A, 16'hD00D, 8'h00, 4'b0001, 8'h80, 3, 2, 8'h01, 4'b0001, -1, 2);
        // Reset while WRITE waits for an ack; then a fresh request.
        rr = alu_ref(6'h05, 8'h3C, 8'h0F, 4'h0);
        txn(6'h05, 16'h1234, 8'h0F, 4'h0, 8'h3C, 1, 5, rr[7:0], rr[11:8], 6, 1);
        rr = alu_ref(6'h00, 8'h12, 8'h34, 4'h0);
        txn(6'h00, 16'h4321, 8'h34, 4'h0, 8'h12, 0, 0, rr[7:0], rr[11:8], -1, 1);
        // An illegal op aborts at once; fOut returns fIn.
        txn(6'h20, 16'hBEEF, 8'h77, 4'b1010, 8'h00, 0, 0, 8'h00, 4'b1010, -1, 1);

        for (int n = 0; n < 160; n++) begin
            o  = ($urandom_range(0, 99) < 88) ? 6'($urandom_range(0, 19))
                                              : 6'($urandom_range(20, 63));
            a  = 16'($urandom);
            y  = 8'($urandom);
            f  = 4'($urandom);
            d  = 8'($urandom);
            rw = $urandom_range(0, 3);
            ww = $urandom_range(1, 3);
            rr = alu_ref(o, d, y, f);
            xr = rr[7:0];
            xf = rr[11:8];
            rk = -1;
            if (o <= 6'h13 && o != 6'h07 && $urandom_range(0, 19) == 0)
                rk = 3 + rw + $urandom_range(0, ww - 1);
            txn(o, a, y, f, d, rw, ww, xr, xf, rk, $urandom_range(0, 2));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
